adder_tree_ctrl_l6: RTL
=======================

# adder_tree_ctrl_L6

Sequencer for the layer-6 four-lane adder-tree/accumulator datapath. On a start pulse it walks the output pixels and, for each pixel, the input-channel groups (N products per group), issuing operand fetch strobes and addresses and driving the accumulator's load strobe. `load_sig` and output-valid are time-aligned to the datapath's fixed pipeline latency. It sits between the layer-6 buffer/address logic and the adder tree, and reports per-pixel results to the write-back stage.

## Interface
- `N`, 4, lanes per group; informational only, no effect on control timing.
- `GW`, 10, width of group counter/count.
- `OW`, 12, width of output-pixel counter/count.
- `PIPE_LAT`, 3, cycles from `rd_en` to operand pair at accumulator input: 1 memory + 1 mult reg + 1 tree reg.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle job start; sampled only in IDLE.
- `num_groups`  in  GW  groups per output pixel; latched at start.
- `num_outputs`  in  OW  output pixels per job; latched at start.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle pulse when the last result has left the accumulator.
- `rd_en`  out  1  operand fetch strobe; one group per cycle.
- `rd_grp`  out  GW  group index of the current fetch.
- `rd_pix`  out  OW  pixel index of the current fetch.
- `load_sig`  out  1  to accumulator `ld`; high on the first group of each pixel.
- `out_valid`  out  1  accumulator/ReLU output holds a finished pixel.
- `out_pix`  out  OW  pixel index qualified by `out_valid`.
- `skip_rd_en`  out  1  skip-tensor fetch strobe; present only with `ADDER_CTRL_SKIP_EN`.

## Operation
- FSM states:
  - IDLE: `start` with both counts nonzero → RUN. `start` with either count zero → DONE directly; no fetches are issued.
  - RUN: `rd_en` = 1 every cycle. `rd_grp` counts 0..num_groups-1. At wrap, `rd_grp` resets to 0 and `rd_pix` increments. After the fetch (num_groups-1, num_outputs-1) → DRAIN.
  - DRAIN: `rd_en` = 0. Waits until the tag pipeline is empty → DONE.
  - DONE: `done` = 1 for one cycle → IDLE.
- Tag pipeline: each fetch pushes {valid, first, last, pix} into a PIPE_LAT-deep shift register.
  - `load_sig` = valid & first at stage PIPE_LAT.
  - A last tag at stage PIPE_LAT produces `out_valid` = 1 and `out_pix` = its pix one cycle later, matching the accumulator register.
- num_groups = 1: every tag is both first and last. `load_sig` is high on every pixel, and `out_valid` then pulses every cycle.
- `start` while not in IDLE is ignored. Counts are latched; input changes during a job have no effect.
- Counters use no saturation. The terminal compare prevents wrap.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `load_sig`, `out_valid`, `skip_rd_en` = 0; `rd_grp`, `rd_pix`, `out_pix` = 0; FSM = IDLE; tag pipeline cleared.
- `start` at cycle 0 → `busy` and first `rd_en` at cycle 1.
- Fetch at cycle t:
  - `load_sig` at t+PIPE_LAT if it is a first group.
  - `out_valid` at t+PIPE_LAT+1 if it is a last group.
- Job length: num_groups·num_outputs fetch cycles. `done` comes PIPE_LAT+2 cycles after the final `rd_en`, and `busy` drops in the same cycle `done` pulses.
- Zero-count start at cycle 0 → `done` at cycle 1; `busy` never rises.
- `rst` mid-job: all outputs fall asynchronously. The partial pixel is discarded and no `done` is issued.

## Configuration
- `ADDER_CTRL_SKIP_EN` defined: `skip_rd_en` exists and pulses PIPE_LAT cycles after the fetch of each pixel's last group. `in_skip` (1-cycle memory) is therefore valid together with `out_valid`.
- `ADDER_CTRL_SKIP_EN` undefined: the port is absent and the datapath's `in_skip` is tied to 0 externally. All other behaviour is identical.

## Test plan
- Reset: assert `rst` async mid-cycle → all outputs 0 immediately; FSM IDLE.
- num_groups = 3, num_outputs = 2, start at cycle 0:
  - `rd_en` cycles 1–6;
  - `load_sig` at 4 and 7;
  - `out_valid` at 7 (pix 0) and 10 (pix 1);
  - `done` at 11.
- num_groups = 1, num_outputs = 4 → `load_sig` high cycles 4–7; `out_valid` cycles 5–8 with pix 0..3.
- num_outputs = 0 → `done` at cycle 1; no `rd_en`, no `busy`.
- Second `start` at cycle 3 of a running job → ignored; counts unchanged; a single `done`.
- `ADDER_CTRL_SKIP_EN`, num_groups = 2, num_outputs = 1 → `skip_rd_en` at cycle 5 and `out_valid` at 6.

Source files
------------

// File: rtl/adder_tree_ctrl_l6_if.sv
// Control bus between the layer-6 adder-tree sequencer and its neighbours.
//   master : the sequencer (takes start/counts, drives fetch, load and result strobes)
//   slave  : buffer/address logic, accumulator and write-back side
// Signals:
//   start, num_groups, num_outputs              job request
//   busy, done                                  job status
//   rd_en, rd_grp, rd_pix                       operand fetch
//   load_sig                                    accumulator load
//   out_valid, out_pix                          finished pixel
//   skip_rd_en                                  skip fetch (ADDER_CTRL_SKIP_EN only)
interface adder_tree_ctrl_l6_if #(
    parameter int GW = 10,
    parameter int OW = 12
);
    logic          start;
    logic [GW-1:0] num_groups;
    logic [OW-1:0] num_outputs;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [GW-1:0] rd_grp;
    logic [OW-1:0] rd_pix;
    logic          load_sig;
    logic          out_valid;
    logic [OW-1:0] out_pix;
`ifdef ADDER_CTRL_SKIP_EN
    logic          skip_rd_en;
`endif

    modport master (
        input  start, num_groups, num_outputs,
        output busy, done, rd_en, rd_grp, rd_pix, load_sig, out_valid, out_pix
`ifdef ADDER_CTRL_SKIP_EN
        , output skip_rd_en
`endif
    );

    modport slave (
        output start, num_groups, num_outputs,
        input  busy, done, rd_en, rd_grp, rd_pix, load_sig, out_valid, out_pix
`ifdef ADDER_CTRL_SKIP_EN
        , input skip_rd_en
`endif
    );
endinterface

// File: rtl/adder_tree_ctrl_l6.sv
// Layer-6 adder-tree/accumulator sequencer.
// On start, walks num_outputs pixels x num_groups groups, one fetch per cycle,
// and carries a {first,last,pix} tag alongside each fetch through a PIPE_LAT-deep
// shift register so load_sig / out_valid line up with the datapath.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  adder_tree_ctrl_l6_if.master (start/counts in; busy, done, rd_*, load_sig,
//        out_valid/out_pix, and skip_rd_en out)
// Optional feature: define ADDER_CTRL_SKIP_EN to drive skip_rd_en, which pulses
// PIPE_LAT cycles after each pixel's last-group fetch.
module adder_tree_ctrl_l6 #(
    parameter int N        = 4,
    parameter int GW       = 10,
    parameter int OW       = 12,
    parameter int PIPE_LAT = 3
) (
    input logic                 clk,
    input logic                 rst,
    adder_tree_ctrl_l6_if.master bus
);
    // N only documents the lane count; control timing does not depend on it.
    if (N < 1) begin : g_n_unsupported
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic          first;
        logic          last;
        logic [OW-1:0] pix;
    } tag_t;

    state_t        state_q, state_d;
    logic [GW-1:0] ng_q, grp_q;
    logic [OW-1:0] no_q, pix_q;
    logic          grp_last, pix_last, rd_en;

    tag_t              tag_pipe [1:PIPE_LAT];
    logic [PIPE_LAT:1] vld_pipe;
    logic              out_valid_q;
    logic [OW-1:0]     out_pix_q;

    assign grp_last = (grp_q == ng_q - GW'(1));
    assign pix_last = (pix_q == no_q - OW'(1));
    assign rd_en    = (state_q == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start)
                      state_d = (bus.num_groups != '0 && bus.num_outputs != '0) ? RUN : DONE;
            RUN:   if (grp_last && pix_last) state_d = DRAIN;
            // Wait for every issued tag to leave the pipe; the final out_valid
            // lands the cycle the pipe goes empty, so done follows it.
            DRAIN: if (vld_pipe == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fetch counters; counts are captured only on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ng_q  <= '0;
            no_q  <= '0;
            grp_q <= '0;
            pix_q <= '0;
        end else if (state_q == IDLE && bus.start) begin
            ng_q  <= bus.num_groups;
            no_q  <= bus.num_outputs;
            grp_q <= '0;
            pix_q <= '0;
        end else if (state_q == RUN) begin
            if (grp_last) begin
                grp_q <= '0;
                // The terminal fetch leaves pix where it is instead of wrapping.
                if (!pix_last) pix_q <= pix_q + OW'(1);
            end else begin
                grp_q <= grp_q + GW'(1);
            end
        end
    end

    // Tag pipe: stage k holds the tag of the fetch issued k cycles earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 1; i <= PIPE_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            tag_pipe[1] <= '{first: (grp_q == '0), last: grp_last, pix: pix_q};
            for (int i = 2; i <= PIPE_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Result strobe sits one register behind the final stage, like the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            out_valid_q <= vld_pipe[PIPE_LAT] & tag_pipe[PIPE_LAT].last;
            if (vld_pipe[PIPE_LAT] && tag_pipe[PIPE_LAT].last)
                out_pix_q <= tag_pipe[PIPE_LAT].pix;
        end
    end

    assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done      = (state_q == DONE);
    assign bus.rd_en     = rd_en;
    assign bus.rd_grp    = grp_q;
    assign bus.rd_pix    = pix_q;
    assign bus.load_sig  = vld_pipe[PIPE_LAT] & tag_pipe[PIPE_LAT].first;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pix   = out_pix_q;
`ifdef ADDER_CTRL_SKIP_EN
    // Skip tensor has a 1-cycle memory, so fetching here makes in_skip valid with out_valid.
    assign bus.skip_rd_en = vld_pipe[PIPE_LAT] & tag_pipe[PIPE_LAT].last;
`endif
endmodule
